alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle ALU. It generalises datapath width and adds barrel-free iterative shifts by a variable amount, an unsigned shift-add multiplier, and carry/overflow flags. It uses a valid/ready handshake on both sides so the execute stage can stall on multi-cycle ops. It sits in the execute stage between the register-file read and the write-back/memory stage.

---
 rtl/alu_seq.sv | 256 +++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle execute-stage ALU with valid/ready on both sides.
// Ports: I_clk/I_reset, I_valid/O_ready request side, I_opcode/I_opcode_mode/
//   I_rA/I_rB/I_immediate operands, O_valid/I_ready result side,
//   O_out result, O_flags {b_zero,a_zero,eq,a_gt_b,b_gt_a}, O_carry,
//   O_overflow, O_illegal.
module alu_seq #(
  parameter int WIDTH     = 16,
  parameter int IMM_WIDTH = 8
) (
  input  logic                 I_clk,
  input  logic                 I_reset,
  input  logic                 I_valid,
  output logic                 O_ready,
  input  logic [3:0]           I_opcode,
  input  logic                 I_opcode_mode,
  input  logic [WIDTH-1:0]     I_rA,
  input  logic [WIDTH-1:0]     I_rB,
  input  logic [IMM_WIDTH-1:0] I_immediate,
  output logic                 O_valid,
  input  logic                 I_ready,
  output logic [WIDTH-1:0]     O_out,
  output logic [4:0]           O_flags,
  output logic                 O_carry,
  output logic                 O_overflow,
  output logic                 O_illegal
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = SH_W + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_LOAD = 4'd6;
  localparam logic [3:0] OP_CMP  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SAR  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_MUL,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [3:0]           op_q;
  logic                 mode_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     out_q;
  logic [4:0]           flags_q;
  logic                 carry_q;
  logic                 ovf_q;
  logic                 ill_q;

  logic                 accept;
  logic                 take;
  logic [SH_W-1:0]      amt;
  logic                 is_shift;
  logic                 is_mul;

  logic [WIDTH:0]       add_w;
  logic [WIDTH:0]       sub_w;
  logic                 a_gt_b;
  logic                 b_gt_a;
  logic [4:0]           cmp_flags;
  logic [WIDTH-1:0]     ld_val;

  logic [WIDTH-1:0]     sc_out;
  logic [4:0]           sc_flags;
  logic                 sc_c;
  logic                 sc_v;
  logic                 sc_ill;

  logic [WIDTH-1:0]     sh_next;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH-1:0]     mul_res;

  assign O_ready = (state_q == S_IDLE) ||
                   ((state_q == S_DONE) && I_ready);
  assign O_valid = (state_q == S_DONE);
  assign accept  = I_valid && O_ready;
  assign take    = O_valid && I_ready;

  assign O_out      = out_q;
  assign O_flags    = flags_q;
  assign O_carry    = carry_q;
  assign O_overflow = ovf_q;
  assign O_illegal  = ill_q;

  assign amt      = I_rB[SH_W-1:0];
  assign is_shift = (I_opcode == OP_SHL) ||
                    (I_opcode == OP_SHR) ||
                    (I_opcode == OP_SAR);
  assign is_mul   = (I_opcode == OP_MUL);

  // Zero-extended operands: bit WIDTH is carry for add, borrow for sub.
  assign add_w = {1'b0, I_rA} + {1'b0, I_rB};
  assign sub_w = {1'b0, I_rA} - {1'b0, I_rB};

  always_comb begin
    a_gt_b = 1'b0;
    b_gt_a = 1'b0;
    if (I_opcode_mode) begin
      a_gt_b = I_rA > I_rB;
      b_gt_a = I_rB > I_rA;
    end else begin
      a_gt_b = $signed(I_rA) > $signed(I_rB);
      b_gt_a = $signed(I_rB) > $signed(I_rA);
    end
  end

  assign cmp_flags = {I_rB == '0, I_rA == '0,
                      I_rA == I_rB, a_gt_b, b_gt_a};

  // Mode 1 places the immediate in the top bits.
  assign ld_val = I_opcode_mode ?
                  (WIDTH'(I_immediate) << (WIDTH - IMM_WIDTH)) :
                  WIDTH'(I_immediate);

  always_comb begin
    sc_out   = '0;
    sc_flags = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_ill   = 1'b0;
    case (I_opcode)
      OP_ADD: begin
        sc_out      = add_w[WIDTH-1:0];
        sc_c        = add_w[WIDTH];
        sc_v        = (I_rA[WIDTH-1] == I_rB[WIDTH-1]) &&
                      (add_w[WIDTH-1] != I_rA[WIDTH-1]);
        sc_flags[2] = (add_w[WIDTH-1:0] == '0);
      end
      OP_SUB: begin
        sc_out      = sub_w[WIDTH-1:0];
        sc_c        = sub_w[WIDTH];
        sc_v        = (I_rA[WIDTH-1] != I_rB[WIDTH-1]) &&
                      (sub_w[WIDTH-1] != I_rA[WIDTH-1]);
        sc_flags[2] = (sub_w[WIDTH-1:0] == '0);
      end
      OP_OR:   sc_out = I_rA | I_rB;
      OP_AND:  sc_out = I_rA & I_rB;
      OP_XOR:  sc_out = I_rA ^ I_rB;
      OP_NOT:  sc_out = ~I_rA;
      OP_LOAD: sc_out = ld_val;
      OP_CMP: begin
        sc_flags = cmp_flags;
        sc_out   = WIDTH'(cmp_flags);
      end
      // Shift by zero completes in one cycle with rA unchanged.
      OP_SHL, OP_SHR, OP_SAR: sc_out = I_rA;
      OP_MUL: sc_out = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  always_comb begin
    sh_next = acc_q[WIDTH-1:0];
    case (op_q)
      OP_SHL:  sh_next = {acc_q[WIDTH-2:0], 1'b0};
      OP_SHR:  sh_next = {1'b0, acc_q[WIDTH-1:1]};
      default: sh_next = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
    endcase
  end

  // Shift-add step: high half accumulates, low half holds remaining
  // multiplier bits; the whole accumulator shifts right each step.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign mul_res  = mode_q ? mul_next[2*WIDTH-1:WIDTH] :
                             mul_next[WIDTH-1:0];

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      mode_q  <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      flags_q <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else if (accept) begin
      op_q   <= I_opcode;
      mode_q <= I_opcode_mode;
      unique case (1'b1)
        is_shift && (amt != '0): begin
          state_q <= S_SHIFT;
          acc_q   <= {{WIDTH{1'b0}}, I_rA};
          cnt_q   <= {1'b0, amt};
          out_q   <= '0;
          flags_q <= '0;
          carry_q <= 1'b0;
          ovf_q   <= 1'b0;
          ill_q   <= 1'b0;
        end
        is_mul: begin
          state_q <= S_MUL;
          acc_q   <= {{WIDTH{1'b0}}, I_rB};
          mcand_q <= I_rA;
          cnt_q   <= CNT_W'(WIDTH);
          out_q   <= '0;
          flags_q <= '0;
          carry_q <= 1'b0;
          ovf_q   <= 1'b0;
          ill_q   <= 1'b0;
        end
        default: begin
          state_q <= S_DONE;
          out_q   <= sc_out;
          flags_q <= sc_flags;
          carry_q <= sc_c;
          ovf_q   <= sc_v;
          ill_q   <= sc_ill;
        end
      endcase
    end else begin
      case (state_q)
        S_SHIFT: begin
          acc_q[WIDTH-1:0] <= sh_next;
          cnt_q            <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_DONE;
            out_q   <= sh_next;
          end
        end
        S_MUL: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_DONE;
            out_q   <= mul_res;
          end
        end
        S_DONE: begin
          if (take) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed bench for alu_seq (WIDTH=16)
// against an arithmetic reference model.
module tb_alu_seq;

  localparam int W  = 16;
  localparam int IW = 8;

  logic          I_clk = 1'b0;
  logic          I_reset;
  logic          I_valid;
  logic          O_ready;
  logic [3:0]    I_opcode;
  logic          I_opcode_mode;
  logic [W-1:0]  I_rA;
  logic [W-1:0]  I_rB;
  logic [IW-1:0] I_immediate;
  logic          O_valid;
  logic          I_ready;
  logic [W-1:0]  O_out;
  logic [4:0]    O_flags;
  logic          O_carry;
  logic          O_overflow;
  logic          O_illegal;

  alu_seq #(.WIDTH(W), .IMM_WIDTH(IW)) dut (
    .I_clk(I_clk),
    .I_reset(I_reset),
    .I_valid(I_valid),
    .O_ready(O_ready),
    .I_opcode(I_opcode),
    .I_opcode_mode(I_opcode_mode),
    .I_rA(I_rA),
    .I_rB(I_rB),
    .I_immediate(I_immediate),
    .O_valid(O_valid),
    .I_ready(I_ready),
    .O_out(O_out),
    .O_flags(O_flags),
    .O_carry(O_carry),
    .O_overflow(O_overflow),
    .O_illegal(O_illegal)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic [W-1:0] out;
    logic [4:0]   flags;
    logic         c;
    logic         v;
    logic         ill;
    int           lat;
  } res_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  function automatic res_t model(input logic [3:0] op,
                                 input logic md,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic [IW-1:0] imm);
    res_t r;
    int sa, sb, s;
    int amt;
    logic [31:0] p;
    logic signed [W-1:0] sga;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    amt = int'(b) % W;
    r.out = '0; r.flags = '0; r.c = 0; r.v = 0; r.ill = 0; r.lat = 1;
    case (op)
      0: begin
        p = 32'(a) + 32'(b);
        r.out = p[W-1:0];
        r.c = p > 32'hFFFF;
        s = sa + sb;
        r.v = (s > 32767) || (s < -32768);
        r.flags[2] = (r.out == 0);
      end
      1: begin
        r.out = a - b;
        r.c = a < b;
        s = sa - sb;
        r.v = (s > 32767) || (s < -32768);
        r.flags[2] = (r.out == 0);
      end
      2: r.out = a | b;
      3: r.out = a & b;
      4: r.out = a ^ b;
      5: r.out = ~a;
      6: r.out = md ? {imm, 8'h00} : {8'h00, imm};
      7: begin
        r.flags[4] = (b == 0);
        r.flags[3] = (a == 0);
        r.flags[2] = (a == b);
        r.flags[1] = md ? (a > b) : (sa > sb);
        r.flags[0] = md ? (b > a) : (sb > sa);
        r.out = {11'd0, r.flags};
      end
      8: begin r.out = a << amt; r.lat = 1 + amt; end
      9: begin r.out = a >> amt; r.lat = 1 + amt; end
      10: begin
        sga = a;
        r.out = sga >>> amt;
        r.lat = 1 + amt;
      end
      11: begin
        p = 32'(a) * 32'(b);
        r.out = md ? p[31:16] : p[15:0];
        r.lat = 1 + W;
      end
      default: r.ill = 1;
    endcase
    return r;
  endfunction

  task automatic run_op(input logic [3:0] op,
                        input logic md,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [IW-1:0] imm,
                        input int hold);
    res_t e;
    int cyc;
    e = model(op, md, a, b, imm);
    chk("rdy_idle", 64'(O_ready), 64'd1);
    I_valid = 1; I_opcode = op; I_opcode_mode = md;
    I_rA = a; I_rB = b; I_immediate = imm;
    I_ready = (hold == 0);
    tick();
    I_valid = 0;
    I_opcode = 4'($urandom);
    I_opcode_mode = 1'($urandom);
    I_rA = W'($urandom);
    I_rB = W'($urandom);
    I_immediate = IW'($urandom);
    cyc = 1;
    while (!O_valid && cyc < 40) begin
      chk("rdy_busy", 64'(O_ready), 64'd0);
      tick();
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(e.lat));
    chk("out", 64'(O_out), 64'(e.out));
    chk("flags", 64'(O_flags), 64'(e.flags));
    chk("carry", 64'(O_carry), 64'(e.c));
    chk("ovf", 64'(O_overflow), 64'(e.v));
    chk("illegal", 64'(O_illegal), 64'(e.ill));
    for (int i = 0; i < hold; i++) begin
      chk("hold_out", 64'(O_out), 64'(e.out));
      chk("hold_vld", 64'(O_valid), 64'd1);
      chk("hold_rdy", 64'(O_ready), 64'd0);
      tick();
    end
    I_ready = 1;
    tick();
    chk("take_vld", 64'(O_valid), 64'd0);
  endtask

  task automatic b2b(input int n);
    logic [3:0]   ops[$];
    logic [W-1:0] as[$];
    logic [W-1:0] bs[$];
    res_t e;
    for (int k = 0; k < n; k++) begin
      ops.push_back(4'($urandom_range(0, 1)));
      as.push_back(W'($urandom));
      bs.push_back(W'($urandom));
    end
    I_valid = 1; I_ready = 1; I_opcode_mode = 0;
    I_opcode = ops[0]; I_rA = as[0]; I_rB = bs[0];
    tick();
    for (int k = 1; k <= n; k++) begin
      e = model(ops[k-1], 1'b0, as[k-1], bs[k-1], '0);
      chk("b2b_vld", 64'(O_valid), 64'd1);
      chk("b2b_out", 64'(O_out), 64'(e.out));
      chk("b2b_carry", 64'(O_carry), 64'(e.c));
      chk("b2b_rdy", 64'(O_ready), 64'd1);
      if (k < n) begin
        I_opcode = ops[k]; I_rA = as[k]; I_rB = bs[k];
      end else begin
        I_valid = 0;
      end
      tick();
    end
    chk("b2b_end", 64'(O_valid), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"}, 64'(O_valid), 64'd0);
    chk({tag, "_out"}, 64'(O_out), 64'd0);
    chk({tag, "_flags"}, 64'(O_flags), 64'd0);
    chk({tag, "_cv"}, 64'({O_carry, O_overflow, O_illegal}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    I_reset = 1; I_valid = 0; I_ready = 1;
    I_opcode = 0; I_opcode_mode = 0;
    I_rA = 0; I_rB = 0; I_immediate = 0;
    tick();
    tick();
    chk_zero("reset");
    I_reset = 0;
    tick();
    chk("rst_rdy", 64'(O_ready), 64'd1);

    run_op(4'd0, 0, 16'h7FFF, 16'h0001, 8'h00, 0);
    run_op(4'd1, 0, 16'h0003, 16'h0005, 8'h00, 0);
    run_op(4'd1, 1, 16'h1234, 16'h1234, 8'h00, 0);
    run_op(4'd0, 0, 16'hFFFF, 16'h0001, 8'h00, 0);
    run_op(4'd7, 0, 16'hFFFF, 16'h0001, 8'h00, 0);
    run_op(4'd7, 1, 16'hFFFF, 16'h0001, 8'h00, 0);
    run_op(4'd7, 0, 16'h0000, 16'h0000, 8'h00, 0);
    run_op(4'd10, 0, 16'h8000, 16'h0003, 8'h00, 0);
    run_op(4'd8, 0, 16'h1234, 16'h0000, 8'h00, 0);
    run_op(4'd9, 0, 16'h8001, 16'h000F, 8'h00, 0);
    run_op(4'd11, 0, 16'h1234, 16'h0100, 8'h00, 0);
    run_op(4'd11, 1, 16'h1234, 16'h0100, 8'h00, 5);
    run_op(4'd11, 1, 16'hFFFF, 16'hFFFF, 8'h00, 0);
    run_op(4'd13, 0, 16'hABCD, 16'h1234, 8'h00, 0);
    run_op(4'd6, 1, 16'h0000, 16'h0000, 8'hA5, 0);
    run_op(4'd6, 0, 16'h0000, 16'h0000, 8'hA5, 0);
    run_op(4'd5, 0, 16'h0F0F, 16'h0000, 8'h00, 2);

    b2b(8);

    I_valid = 1; I_opcode = 4'd11; I_opcode_mode = 0;
    I_rA = 16'h1234; I_rB = 16'h5678;
    tick();
    I_valid = 0;
    repeat (4) tick();
    I_reset = 1;
    tick();
    chk_zero("midrst");
    I_reset = 0;
    chk("midrst_rdy", 64'(O_ready), 64'd1);
    seen = 0;
    repeat (20) begin
      tick();
      if (O_valid) seen++;
    end
    chk("midrst_novld", 64'(seen), 64'd0);

    for (int k = 0; k < 80; k++) begin
      run_op(4'($urandom), 1'($urandom), W'($urandom), W'($urandom),
             IW'($urandom), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
